// File: rtl/alu_arbiter_if.sv
// Handshake bundle between the two requesters, the shared ALU and alu_arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface alu_arbiter_if #(
    parameter int DW   = 4,
    parameter int OPW  = 3,
    parameter int CNTW = 8
);
    logic            req0_valid;
    logic            req0_ready;
    logic [DW-1:0]   req0_a;
    logic [DW-1:0]   req0_b;
    logic [OPW-1:0]  req0_op;

    logic            req1_valid;
    logic            req1_ready;
    logic [DW-1:0]   req1_a;
    logic [DW-1:0]   req1_b;
    logic [OPW-1:0]  req1_op;

    logic            resp0_valid;
    logic            resp0_ready;
    logic            resp1_valid;
    logic            resp1_ready;
    logic [DW-1:0]   resp_data;

    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [OPW-1:0]  alu_op;
    logic [DW-1:0]   alu_res;

    logic            busy;
    logic            grant_id;
    logic [CNTW-1:0] done_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  resp0_ready, resp1_ready, alu_res,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        output alu_a, alu_b, alu_op, busy, grant_id, done_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output resp0_ready, resp1_ready, alu_res,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        input  alu_a, alu_b, alu_op, busy, grant_id, done_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One transaction at a time: IDLE (accept) -> EXEC (settle) -> RESP (hand back).
module alu_arbiter #(
    parameter int DW   = 4,
    parameter int OPW  = 3,
    parameter int CNTW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic            r_grant_id;
    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [OPW-1:0]  r_alu_op;
    logic [DW-1:0]   r_resp_data;
    logic [CNTW-1:0] r_done_cnt;

    logic            w_winner;
    logic            w_accept;
    logic            w_complete;
    logic            w_resp_ready_sel;
    logic            w_req0_ready;
    logic            w_req1_ready;
    logic            w_resp0_valid;
    logic            w_resp1_valid;

    // Contention goes to whoever did not win last; a lone request simply wins.
    assign w_winner         = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant
                                                                 : bus.req1_valid;
    assign w_resp_ready_sel = r_grant_id ? bus.resp1_ready : bus.resp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of process ordering.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that leaves
        // one unassigned would otherwise infer a latch.
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_complete    = 1'b0;
        w_req0_ready  = 1'b0;
        w_req1_ready  = 1'b0;
        w_resp0_valid = 1'b0;
        w_resp1_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // rst_n gating keeps ready low while reset is held with valid asserted.
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    w_accept     = 1'b1;
                    w_req0_ready = ~w_winner;
                    w_req1_ready = w_winner;
                    w_state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp0_valid = ~r_grant_id;
                w_resp1_valid = r_grant_id;
                if (w_resp_ready_sel) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_grant_id   <= 1'b0;
            r_resp_data  <= '0;
            r_last_grant <= 1'b1;
            r_done_cnt   <= '0;
        end else begin
            // The payload is copied on acceptance, so later requester changes are harmless.
            if (w_accept) begin
                r_alu_a    <= w_winner ? bus.req1_a  : bus.req0_a;
                r_alu_b    <= w_winner ? bus.req1_b  : bus.req0_b;
                r_alu_op   <= w_winner ? bus.req1_op : bus.req0_op;
                r_grant_id <= w_winner;
            end
            if (r_state == S_EXEC) begin
                r_resp_data <= bus.alu_res;
            end
            if (w_complete) begin
                r_last_grant <= r_grant_id;
                r_done_cnt   <= r_done_cnt + CNTW'(1);
            end
        end
    end

    assign bus.req0_ready  = w_req0_ready;
    assign bus.req1_ready  = w_req1_ready;
    assign bus.resp0_valid = w_resp0_valid;
    assign bus.resp1_valid = w_resp1_valid;
    assign bus.resp_data   = r_resp_data;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.grant_id    = r_grant_id;
    assign bus.done_cnt    = r_done_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, randomized traffic
// against a transaction-level model, plus reset-in-flight and counter-wrap sequences.
module tb_alu_arbiter;

    typedef struct {
        logic       v0;
        logic       v1;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [2:0] op0;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [2:0] op1;
        int         hold;
        logic       exp_g;
        logic [3:0] exp_res;
    } txn_t;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    // Transaction-level model state
    logic       m_last;
    int         m_cnt;
    logic [3:0] m_alu_a;

    alu_arbiter_if #(.DW(4), .OPW(3), .CNTW(8)) bus ();

    alu_arbiter #(.DW(4), .OPW(3), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return (a < b) ? 4'd1 : 4'd0;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return ~a;
            default: return (a == b) ? 4'd1 : 4'd0;
        endcase
    endfunction

    // The ALU itself lives in the bench
    assign bus.alu_res = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: no summary reached, time limit %0d", 500000);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic v0, input logic v1,
                                input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                                input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                                input int hold, input logic g, input logic [3:0] res);
        txn_t t;
        t.v0 = v0; t.v1 = v1;
        t.a0 = a0; t.b0 = b0; t.op0 = op0;
        t.a1 = a1; t.b1 = b1; t.op1 = op1;
        t.hold = hold; t.exp_g = g; t.exp_res = res;
        return t;
    endfunction

    task automatic drive_idle();
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
    task automatic run_txn(input txn_t t);
        logic g;
        g = t.exp_g;
        bus.req0_valid = t.v0; bus.req0_a = t.a0; bus.req0_b = t.b0; bus.req0_op = t.op0;
        bus.req1_valid = t.v1; bus.req1_a = t.a1; bus.req1_b = t.b1; bus.req1_op = t.op1;
        #1;
        check("idle_req0_ready", bus.req0_ready, !g);
        check("idle_req1_ready", bus.req1_ready, g);
        check("idle_busy", bus.busy, 0);
        @(negedge clk);
        check("exec_busy", bus.busy, 1);
        check("exec_grant_id", bus.grant_id, g);
        check("exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
        check("exec_resp_valid", {bus.resp0_valid, bus.resp1_valid}, 0);
        check("exec_alu_a", bus.alu_a, g ? t.a1 : t.a0);
        check("exec_alu_op", bus.alu_op, g ? t.op1 : t.op0);
        if (g) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
        bus.req0_a = ~t.a0; bus.req0_b = ~t.b0; bus.req0_op = ~t.op0;
        bus.req1_a = ~t.a1; bus.req1_b = ~t.b1; bus.req1_op = ~t.op1;
        @(negedge clk);
        check("resp0_valid", bus.resp0_valid, !g);
        check("resp1_valid", bus.resp1_valid, g);
        check("resp_data", bus.resp_data, t.exp_res);
        for (int i = 0; i < t.hold; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            if (g) bus.resp0_ready = 1'b1;
            else   bus.resp1_ready = 1'b1;
            @(negedge clk);
            check("hold_valid", g ? bus.resp1_valid : bus.resp0_valid, 1);
            check("hold_data", bus.resp_data, t.exp_res);
            check("hold_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
            check("hold_busy", bus.busy, 1);
        end
        bus.resp0_ready = !g;
        bus.resp1_ready = g;
        @(negedge clk);
        m_cnt++;
        m_last  = g;
        m_alu_a = g ? t.a1 : t.a0;
        check("done_busy", bus.busy, 0);
        check("done_cnt", bus.done_cnt, m_cnt % 256);
        check("done_resp_valid", {bus.resp0_valid, bus.resp1_valid}, 0);
        drive_idle();
    endtask

    task automatic idle_cycle();
        drive_idle();
        #1;
        check("noreq_ready", {bus.req0_ready, bus.req1_ready}, 0);
        @(negedge clk);
        check("noreq_busy", bus.busy, 0);
        check("noreq_alu_a_hold", bus.alu_a, m_alu_a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_grant_id"}, bus.grant_id, 0);
        check({tag, "_alu_abop"}, {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
        check({tag, "_resp_data"}, bus.resp_data, 0);
        check({tag, "_done_cnt"}, bus.done_cnt, 0);
        check({tag, "_valid_ready"},
              {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid}, 0);
    endtask

    txn_t vec[10];

    initial begin
        txn_t       t;
        logic [1:0] r;

        n_vec = 0;
        n_err = 0;
        m_last  = 1'b1;
        m_cnt   = 0;
        m_alu_a = 4'h0;

        vec[0] = mk(1, 1, 4'h3, 4'h1, 3'd1, 4'hF, 4'h6, 3'd3, 0, 0, 4'h2);
        vec[1] = mk(1, 1, 4'h3, 4'h1, 3'd1, 4'hF, 4'h6, 3'd3, 1, 1, 4'h6);
        vec[2] = mk(1, 1, 4'h3, 4'h1, 3'd1, 4'hF, 4'h6, 3'd3, 0, 0, 4'h2);
        vec[3] = mk(1, 1, 4'h3, 4'h1, 3'd1, 4'hF, 4'h6, 3'd3, 0, 1, 4'h6);
        vec[4] = mk(1, 0, 4'h7, 4'h5, 3'd0, 4'h0, 4'h0, 3'd0, 0, 0, 4'hC);
        vec[5] = mk(1, 0, 4'h8, 4'h1, 3'd4, 4'h0, 4'h0, 3'd0, 5, 0, 4'h9);
        vec[6] = mk(0, 1, 4'h0, 4'h0, 3'd0, 4'hA, 4'h5, 3'd5, 2, 1, 4'hF);
        vec[7] = mk(1, 0, 4'h5, 4'h5, 3'd7, 4'h0, 4'h0, 3'd0, 0, 0, 4'h1);
        vec[8] = mk(1, 1, 4'h2, 4'h3, 3'd2, 4'hC, 4'h0, 3'd6, 0, 1, 4'h3);
        vec[9] = mk(1, 1, 4'h2, 4'h3, 3'd2, 4'hC, 4'h0, 3'd6, 0, 0, 4'h1);

        rst_n = 1'b0;
        drive_idle();
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: fairness, single requesters, backpressure
        for (int i = 0; i < 10; i++) begin
            run_txn(vec[i]);
        end

        // Random traffic against the model; runs past 256 completions to see the wrap
        while (m_cnt < 262) begin
            if ($urandom_range(0, 7) == 0) idle_cycle();
            r      = 2'($urandom_range(1, 3));
            t.v0   = r[0];
            t.v1   = r[1];
            t.a0   = 4'($urandom); t.b0 = 4'($urandom); t.op0 = 3'($urandom);
            t.a1   = 4'($urandom); t.b1 = 4'($urandom); t.op1 = 3'($urandom);
            t.hold = int'($urandom_range(0, 2));
            t.exp_g   = (t.v0 && t.v1) ? ~m_last : t.v1;
            t.exp_res = t.exp_g ? alu_f(t.a1, t.b1, t.op1) : alu_f(t.a0, t.b0, t.op0);
            run_txn(t);
            if (m_cnt == 256) check("wrap_done_cnt", bus.done_cnt, 0);
        end

        // Reset in the middle of a transaction owned by req1
        run_txn(mk(1, 0, 4'h4, 4'h2, 3'd0, 4'h0, 4'h0, 3'd0, 0, 0, 4'h6));
        bus.req0_valid = 1'b1; bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_op = 3'd0;
        bus.req1_valid = 1'b1; bus.req1_a = 4'h2; bus.req1_b = 4'h2; bus.req1_op = 3'd0;
        @(negedge clk);
        check("pre_rst_grant", bus.grant_id, 1);
        check("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check("midrst_no_resp", {bus.resp0_valid, bus.resp1_valid}, 0);
        rst_n   = 1'b1;
        m_last  = 1'b1;
        m_cnt   = 0;
        m_alu_a = 4'h0;
        run_txn(mk(1, 1, 4'h9, 4'h3, 3'd1, 4'h4, 4'h4, 3'd7, 0, 0, 4'h6));
        run_txn(mk(1, 1, 4'h9, 4'h3, 3'd1, 4'h4, 4'h4, 3'd7, 0, 1, 4'h1));
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
